// File: rtl/ren_dispatch_if.sv
// rtl/ren_dispatch_if.sv - rename-to-dispatch and dispatch-to-queue handshake bundle
interface ren_dispatch_if #(
    parameter int RENISS_WIDTH = 151
);
    logic                    REN_valid_IN;
    logic [RENISS_WIDTH-1:0] REN_data_IN;
    logic                    REN_stall_OUT;
    logic                    IQ_full_IN;
    logic                    IQ_pushReq_OUT;
    logic [RENISS_WIDTH-1:0] IQ_pushData_OUT;
    logic                    LSQ_full_IN;
    logic                    LSQ_pushReq_OUT;
    logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT;

    // Environment side: rename stage plus the two downstream queues.
    modport master (
        output REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
        input  REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
               LSQ_pushReq_OUT, LSQ_pushData_OUT
    );

    modport slave (
        input  REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
        output REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
               LSQ_pushReq_OUT, LSQ_pushData_OUT
    );
endinterface

// File: rtl/ren_dispatch.sv
// rtl/ren_dispatch.sv - in-order dispatch buffer steering renamed instructions to the IQ or LSQ
module ren_dispatch #(
    parameter int RENISS_WIDTH    = 151,
    parameter int DISP_DEPTH_LOG2 = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               FREEZE,
    input  logic               FLUSH_IN,
    ren_dispatch_if.slave      disp,
    output logic [31:0]        IQ_dispCount_OUT,
    output logic [31:0]        LSQ_dispCount_OUT,
    output logic [31:0]        stallCycles_OUT
);
    localparam int DEPTH = 1 << DISP_DEPTH_LOG2;

    typedef logic [DISP_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DISP_DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [RENISS_WIDTH-1:0] mem_q [DEPTH];
    ptr_t  rd_ptr_q, rd_ptr_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    cnt_t  count_q, count_d;
    logic [31:0] iq_cnt_q, iq_cnt_d;
    logic [31:0] lsq_cnt_q, lsq_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic                    not_empty;
    logic [RENISS_WIDTH-1:0] head;
    logic                    head_is_mem;
    logic                    stall;
    logic                    dispatch_ok;
    logic                    iq_push;
    logic                    lsq_push;
    logic                    accept;
    logic                    pop;

    // Stall depends only on registered occupancy and FREEZE, never on queue fullness.
    always_comb begin
        not_empty   = (count_q != '0);
        head        = mem_q[rd_ptr_q];
        head_is_mem = head[40] | head[39];
        stall       = (count_q == DEPTH_C) || FREEZE;
        dispatch_ok = not_empty && !FREEZE && !FLUSH_IN;
        iq_push     = dispatch_ok && !head_is_mem && !disp.IQ_full_IN;
        lsq_push    = dispatch_ok &&  head_is_mem && !disp.LSQ_full_IN;
        accept      = disp.REN_valid_IN && !stall && !FLUSH_IN;
        pop         = iq_push || lsq_push;
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        iq_cnt_d    = iq_cnt_q + (iq_push ? 32'd1 : 32'd0);
        lsq_cnt_d   = lsq_cnt_q + (lsq_push ? 32'd1 : 32'd0);
        // Frozen cycles hold every counter, including the stall statistic.
        stall_cnt_d = stall_cnt_q +
                      ((disp.REN_valid_IN && stall && !FREEZE) ? 32'd1 : 32'd0);
        if (FLUSH_IN) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= disp.REN_data_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            iq_cnt_q    <= '0;
            lsq_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            iq_cnt_q    <= iq_cnt_d;
            lsq_cnt_q   <= lsq_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign disp.REN_stall_OUT    = stall;
    assign disp.IQ_pushReq_OUT   = iq_push;
    assign disp.LSQ_pushReq_OUT  = lsq_push;
    assign disp.IQ_pushData_OUT  = not_empty ? head : '0;
    assign disp.LSQ_pushData_OUT = not_empty ? head : '0;
    assign IQ_dispCount_OUT      = iq_cnt_q;
    assign LSQ_dispCount_OUT     = lsq_cnt_q;
    assign stallCycles_OUT       = stall_cnt_q;
endmodule

// File: tb/tb_ren_dispatch.sv
// tb/tb_ren_dispatch.sv - directed bench for ren_dispatch
module tb_ren_dispatch;
    logic CLK = 1'b0;
    logic RESET;
    logic FREEZE;
    logic FLUSH_IN;
    logic [31:0] IQ_dispCount_OUT;
    logic [31:0] LSQ_dispCount_OUT;
    logic [31:0] stallCycles_OUT;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    ren_dispatch_if #(.RENISS_WIDTH(151)) bus ();

    ren_dispatch #(
        .RENISS_WIDTH(151),
        .DISP_DEPTH_LOG2(2)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .FREEZE           (FREEZE),
        .FLUSH_IN         (FLUSH_IN),
        .disp             (bus),
        .IQ_dispCount_OUT (IQ_dispCount_OUT),
        .LSQ_dispCount_OUT(LSQ_dispCount_OUT),
        .stallCycles_OUT  (stallCycles_OUT)
    );

    function automatic logic [150:0] mk(input int k, input logic [1:0] mb);
        logic [150:0] w;
        w          = '0;
        w[150:135] = 16'(k);
        w[30:0]    = 31'(32'h1000 + k);
        w[40:39]   = mb;
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [150:0] obs, input logic [150:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; FREEZE = 1'b0; FLUSH_IN = 1'b0;
        bus.REN_valid_IN = 1'b0; bus.REN_data_IN = '0;
        bus.IQ_full_IN = 1'b0; bus.LSQ_full_IN = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        #1;
        check("rst_stall", bus.REN_stall_OUT, 0);
        check("rst_iq_req", bus.IQ_pushReq_OUT, 0);
        check("rst_lsq_req", bus.LSQ_pushReq_OUT, 0);
        check("rst_iq_data", bus.IQ_pushData_OUT, 0);
        check("rst_lsq_data", bus.LSQ_pushData_OUT, 0);
        check("rst_stats", {IQ_dispCount_OUT, LSQ_dispCount_OUT, stallCycles_OUT}, 0);

        // ALU pass-through
        bus.REN_valid_IN = 1'b1; bus.REN_data_IN = mk(1, 2'b00);
        tick();
        bus.REN_valid_IN = 1'b0;
        #1;
        check("alu_iq_req", bus.IQ_pushReq_OUT, 1);
        check("alu_iq_data", bus.IQ_pushData_OUT, mk(1, 2'b00));
        check("alu_lsq_req", bus.LSQ_pushReq_OUT, 0);
        tick();
        check("alu_iq_cnt", IQ_dispCount_OUT, 1);
        check("alu_empty_req", bus.IQ_pushReq_OUT, 0);
        check("alu_empty_data", bus.IQ_pushData_OUT, 0);

        // In-order blocking behind a load
        bus.LSQ_full_IN = 1'b1;
        bus.REN_valid_IN = 1'b1; bus.REN_data_IN = mk(2, 2'b01);
        tick();
        bus.REN_data_IN = mk(3, 2'b00);
        tick();
        bus.REN_valid_IN = 1'b0;
        #1;
        check("blk_iq_req", bus.IQ_pushReq_OUT, 0);
        check("blk_lsq_req", bus.LSQ_pushReq_OUT, 0);
        check("blk_lsq_data", bus.LSQ_pushData_OUT, mk(2, 2'b01));
        tick();
        check("blk_hold_iq", bus.IQ_pushReq_OUT, 0);
        bus.LSQ_full_IN = 1'b0;
        #1;
        check("blk_rel_lsq", bus.LSQ_pushReq_OUT, 1);
        check("blk_rel_iq", bus.IQ_pushReq_OUT, 0);
        tick();
        bus.LSQ_full_IN = 1'b1;
        #1;
        check("blk_alu_iq", bus.IQ_pushReq_OUT, 1);
        check("blk_alu_data", bus.IQ_pushData_OUT, mk(3, 2'b00));
        check("blk_alu_lsq", bus.LSQ_pushReq_OUT, 0);
        tick();
        bus.LSQ_full_IN = 1'b0;
        check("blk_lsq_cnt", LSQ_dispCount_OUT, 1);
        check("blk_iq_cnt", IQ_dispCount_OUT, 2);

        // Full buffer and rename stall
        bus.IQ_full_IN = 1'b1;
        bus.REN_valid_IN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.REN_data_IN = mk(10 + i, 2'b00);
            #1;
            check("full_stall_pre", bus.REN_stall_OUT, (i >= 4) ? 1 : 0);
            tick();
        end
        bus.REN_valid_IN = 1'b0;
        #1;
        check("full_stall", bus.REN_stall_OUT, 1);
        check("full_stall_cnt", stallCycles_OUT, 2);
        check("full_count", dut.count_q, 4);
        check("full_iq_req", bus.IQ_pushReq_OUT, 0);
        bus.IQ_full_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_drain_req", bus.IQ_pushReq_OUT, 1);
            check("full_drain_data", bus.IQ_pushData_OUT, mk(10 + i, 2'b00));
            tick();
        end
        check("full_drain_cnt", IQ_dispCount_OUT, 6);
        check("full_drain_stall", bus.REN_stall_OUT, 0);

        // Simultaneous accept and dispatch with pointer wrap
        bus.IQ_full_IN = 1'b1;
        bus.REN_valid_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.REN_data_IN = mk(20 + i, 2'b00);
            tick();
        end
        bus.IQ_full_IN = 1'b0;
        for (int i = 3; i < 10; i++) begin
            bus.REN_data_IN = mk(20 + i, 2'b00);
            #1;
            check("flow_req", bus.IQ_pushReq_OUT, 1);
            check("flow_data", bus.IQ_pushData_OUT, mk(20 + i - 3, 2'b00));
            tick();
            check("flow_count", dut.count_q, 3);
        end
        bus.REN_valid_IN = 1'b0;
        for (int i = 7; i < 10; i++) begin
            #1;
            check("flow_tail_req", bus.IQ_pushReq_OUT, 1);
            check("flow_tail_data", bus.IQ_pushData_OUT, mk(20 + i, 2'b00));
            tick();
        end
        check("flow_count_end", dut.count_q, 0);
        check("flow_iq_cnt", IQ_dispCount_OUT, 16);

        // Flush with three buffered entries
        bus.IQ_full_IN = 1'b1;
        bus.REN_valid_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.REN_data_IN = mk(30 + i, 2'b00);
            tick();
        end
        bus.REN_valid_IN = 1'b0;
        bus.IQ_full_IN = 1'b0;
        FLUSH_IN = 1'b1;
        #1;
        check("flush_iq_req", bus.IQ_pushReq_OUT, 0);
        check("flush_lsq_req", bus.LSQ_pushReq_OUT, 0);
        tick();
        FLUSH_IN = 1'b0;
        #1;
        check("flush_count", dut.count_q, 0);
        check("flush_after_req", bus.IQ_pushReq_OUT, 0);
        check("flush_after_data", bus.IQ_pushData_OUT, 0);
        check("flush_iq_cnt", IQ_dispCount_OUT, 16);

        // Freeze holds state, then reset under freeze clears it
        bus.IQ_full_IN = 1'b1;
        bus.REN_valid_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.REN_data_IN = mk(40 + i, 2'b00);
            tick();
        end
        bus.IQ_full_IN = 1'b0;
        FREEZE = 1'b1;
        bus.REN_data_IN = mk(43, 2'b00);
        #1;
        check("frz_stall", bus.REN_stall_OUT, 1);
        check("frz_iq_req", bus.IQ_pushReq_OUT, 0);
        tick();
        check("frz_count", dut.count_q, 3);
        check("frz_stall_cnt", stallCycles_OUT, 2);
        check("frz_iq_cnt", IQ_dispCount_OUT, 16);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        FREEZE = 1'b0;
        bus.REN_valid_IN = 1'b0;
        #1;
        check("rstf_count", dut.count_q, 0);
        check("rstf_iq_req", bus.IQ_pushReq_OUT, 0);
        check("rstf_data", bus.IQ_pushData_OUT, 0);
        check("rstf_stats", {IQ_dispCount_OUT, LSQ_dispCount_OUT, stallCycles_OUT}, 0);
        check("rstf_stall", bus.REN_stall_OUT, 0);

        // Store (bit 40) goes to the LSQ
        bus.REN_valid_IN = 1'b1; bus.REN_data_IN = mk(50, 2'b10);
        tick();
        bus.REN_valid_IN = 1'b0;
        #1;
        check("st_lsq_req", bus.LSQ_pushReq_OUT, 1);
        check("st_iq_req", bus.IQ_pushReq_OUT, 0);
        check("st_lsq_data", bus.LSQ_pushData_OUT, mk(50, 2'b10));
        tick();
        check("st_lsq_cnt", LSQ_dispCount_OUT, 1);
        check("st_iq_cnt", IQ_dispCount_OUT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
